// File: rtl/test_003_pkg.sv
// test_003 shared definitions: FSM state encoding, default geometry and the
// closed-form sum of squares used as the reference for the self-check.
package test_003_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FILL,
    SUM,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Sum of i*i for i = 0 .. depth-1.
  function automatic longint unsigned sum_of_squares(input longint unsigned depth);
    return (depth * (depth - 1) * (2 * depth - 1)) / 6;
  endfunction

endpackage

// File: rtl/test_003_ram.sv
// test_003_ram: single-port synchronous RAM, DEPTH x WIDTH, registered read
// data (one-cycle latency), no reset on storage or read register.
module test_003_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/test_003.sv
// test_003: method-execution block. On request, fills a DEPTH-entry RAM with
// a[i] = i*i, sums it back out and publishes the sum on test_return.
// Optional self-check of the sum is enabled by defining TEST003_SELFCHECK_EN;
// without it test_ok is tied high.
module test_003
  import test_003_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             test_req,
  output logic             test_busy,
  output logic [WIDTH-1:0] test_return,
  output logic             test_ok
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] acc;
  logic             rd_done;
  logic             rd_valid;
  logic             ram_we;
  logic             ram_re;
  logic [WIDTH-1:0] idx_ext;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  assign idx_ext   = WIDTH'(idx);
  assign ram_wdata = idx_ext * idx_ext;
  assign ram_we    = (state == FILL);
  assign ram_re    = (state == SUM) && !rd_done;

  test_003_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Method FSM: index counter, accumulator, busy and result registers.
  // SUM issues reads while rd_done is low; rd_valid tracks the one-cycle RAM
  // latency so the final word is accumulated in the extra SUM cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      test_busy   <= 1'b0;
      test_return <= '0;
      idx         <= '0;
      acc         <= '0;
      rd_done     <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= ram_re;
      case (state)
        IDLE: begin
          if (test_req) begin
            state     <= INIT;
            test_busy <= 1'b1;
          end
        end
        INIT: begin
          idx     <= '0;
          acc     <= '0;
          rd_done <= 1'b0;
          state   <= FILL;
        end
        FILL: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= SUM;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        SUM: begin
          if (rd_valid) begin
            acc <= acc + ram_rdata;
          end
          if (!rd_done) begin
            if (idx == LAST_IDX) begin
              rd_done <= 1'b1;
            end else begin
              idx <= idx + AW'(1);
            end
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          test_return <= acc;
          test_busy   <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          test_busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef TEST003_SELFCHECK_EN
  localparam logic [WIDTH-1:0] EXP_SUM = WIDTH'(sum_of_squares(longint'(DEPTH)));

  // Self-check flag: cleared on reset and when a run starts, set from DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      test_ok <= 1'b0;
    end else if (state == IDLE && test_req) begin
      test_ok <= 1'b0;
    end else if (state == DONE) begin
      test_ok <= (acc == EXP_SUM);
    end
  end
`else
  assign test_ok = 1'b1;
`endif

endmodule

// File: tb/tb_test_003.sv
// Self-checking bench for test_003: three instances (DEPTH 16, 2, 256) share
// clock, reset and request, as in the generated system.
module tb_test_003;

  logic        clk = 1'b0;
  logic        reset;
  logic        test_req;
  logic        b0, b1, b2;
  logic [31:0] r0, r1, r2;
  logic        k0, k1, k2;

  int errors = 0;
  int checks = 0;

`ifdef TEST003_SELFCHECK_EN
  localparam logic OK_RST = 1'b0;
`else
  localparam logic OK_RST = 1'b1;
`endif

  typedef struct {
    int unsigned idx;
    int unsigned exp_len;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t        vecs[3];
  int unsigned meas_len[3];

  always #5 clk = ~clk;

  test_003 #(.DEPTH(16), .WIDTH(32)) dut16 (
    .clk(clk), .reset(reset), .test_req(test_req),
    .test_busy(b0), .test_return(r0), .test_ok(k0)
  );
  test_003 #(.DEPTH(2), .WIDTH(32)) dut2 (
    .clk(clk), .reset(reset), .test_req(test_req),
    .test_busy(b1), .test_return(r1), .test_ok(k1)
  );
  test_003 #(.DEPTH(256), .WIDTH(32)) dut256 (
    .clk(clk), .reset(reset), .test_req(test_req),
    .test_busy(b2), .test_return(r2), .test_ok(k2)
  );

  function automatic logic busy_of(input int unsigned k);
    case (k)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  function automatic logic [31:0] ret_of(input int unsigned k);
    case (k)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic ok_of(input int unsigned k);
    case (k)
      0:       return k0;
      1:       return k1;
      default: return k2;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_all_idle;
    int unsigned n = 0;
    while ((b0 | b1 | b2) && n < 1000) begin
      tick();
      n++;
    end
    chk("idle_timeout", {29'd0, b0, b1, b2}, 32'd0);
  endtask

  // Start a run with a one-cycle request and measure each instance's busy
  // length. With toggle set, req wiggles for the first 30 cycles of the run.
  task automatic measure(input bit toggle);
    bit done[3];
    for (int k = 0; k < 3; k++) begin
      done[k]     = 1'b0;
      meas_len[k] = 0;
    end
    test_req = 1'b1;
    tick();
    chk("busy_rise", {31'd0, b0}, 32'd1);
    for (int c = 0; c < 800 && !(done[0] && done[1] && done[2]); c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!done[k]) begin
          if (busy_of(k)) meas_len[k]++;
          else if (meas_len[k] > 0) done[k] = 1'b1;
        end
      end
      test_req = (toggle && c >= 1 && c <= 30) ? (c % 2 == 1) : 1'b0;
      tick();
    end
    chk("measure_timeout", {29'd0, done[0], done[1], done[2]}, 32'd7);
    test_req = 1'b0;
    wait_all_idle();
  endtask

  task automatic check_table(input bit only0);
    for (int i = 0; i < 3; i++) begin
      if (only0 && i != 0) continue;
      chk($sformatf("busy_len[%0d]", i), meas_len[vecs[i].idx], vecs[i].exp_len);
      chk($sformatf("return[%0d]", i), ret_of(vecs[i].idx), vecs[i].exp_ret);
      chk($sformatf("ok[%0d]", i), {31'd0, ok_of(vecs[i].idx)}, 32'd1);
    end
  endtask

  initial begin
    logic        prev;
    int unsigned run;
    bit          seen_rise;
    int unsigned falls;

    vecs[0] = '{idx: 0, exp_len: 35,  exp_ret: 32'd1240};
    vecs[1] = '{idx: 1, exp_len: 7,   exp_ret: 32'd1};
    vecs[2] = '{idx: 2, exp_len: 515, exp_ret: 32'd5559680};

    // Reset for 5 cycles with no request.
    reset    = 1'b1;
    test_req = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy[%0d]", k), {31'd0, busy_of(k)}, 32'd0);
      chk($sformatf("rst_return[%0d]", k), ret_of(k), 32'd0);
      chk($sformatf("rst_ok[%0d]", k), {31'd0, ok_of(k)}, {31'd0, OK_RST});
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_busy", {29'd0, b0, b1, b2}, 32'd0);
    end

    // Single pulse: all three depths.
    measure(1'b0);
    check_table(1'b0);

    // Request held high: one idle cycle between 35-cycle runs.
    test_req  = 1'b1;
    prev      = b0;
    run       = 0;
    seen_rise = 1'b0;
    falls     = 0;
    for (int c = 0; c < 154; c++) begin
      tick();
      if (b0 != prev) begin
        if (prev) begin
          falls++;
          chk("hold_busy_len", run, 35);
          chk("hold_return", r0, 32'd1240);
        end else if (seen_rise) begin
          chk("hold_idle_len", run, 1);
        end
        if (b0) seen_rise = 1'b1;
        run  = 1;
        prev = b0;
      end else begin
        run++;
      end
    end
    chk("hold_falls", falls, 4);
    test_req = 1'b0;
    wait_all_idle();

    // Reset ten cycles into a run.
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
    repeat (9) tick();
    chk("pre_reset_busy", {31'd0, b0}, 32'd1);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_busy[%0d]", k), {31'd0, busy_of(k)}, 32'd0);
      chk($sformatf("midrst_return[%0d]", k), ret_of(k), 32'd0);
      chk($sformatf("midrst_ok[%0d]", k), {31'd0, ok_of(k)}, {31'd0, OK_RST});
    end
    reset = 1'b0;
    tick();
    measure(1'b0);
    check_table(1'b0);

    // Request toggled during a run: DEPTH=16 instance unaffected.
    measure(1'b1);
    check_table(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_003.md
# test_003

Self-contained method-execution block in the Synthesijer-generated style: a `test` method started by a level request, reported busy until done. Each run fills an internal DEPTH-entry array with a[i] = i*i, sums it, and publishes the sum on a result port. It runs in parallel with other generated test blocks, all sharing one clock, one reset and one request line.

## Interface

Parameters:
- `DEPTH`, 16: array entries; legal range 2..256.
- `WIDTH`, 32: data and result width.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `test_req`, input, 1: level-sensitive method request.
- `test_busy`, output, 1: method is executing.
- `test_return`, output, WIDTH: sum from the last completed run.
- `test_ok`, output, 1: self-check result (see Configuration).

## Operation

FSM states are IDLE, INIT, FILL, SUM, DONE.
- IDLE: `test_busy`=0. If `test_req`=1, go to INIT.
- INIT: i←0, acc←0. Go to FILL.
- FILL: write a[i]←i*i (WIDTH bits), i←i+1. After writing index DEPTH-1: i←0, go to SUM.
- SUM: issue a read of a[i] each cycle; accumulate the read data returned one cycle later. After the last data word is accumulated, go to DONE.
- DONE: `test_return`←acc. Go to IDLE.

Behaviour rules:
- `test_busy`=1 in every state except IDLE. It is registered from the next state, so busy rises in the cycle INIT is entered.
- Arithmetic is unsigned, modulo 2^WIDTH.
- The index is $clog2(DEPTH) bits. The end-of-fill compare is against DEPTH-1, so the index never wraps past DEPTH-1.
- Request held high through DONE: the block passes through IDLE for exactly one cycle (busy=0), then restarts.
- Request deasserted during a run: ignored. The run always completes.
- Reset mid-run: the next edge forces IDLE, busy=0 and `test_return`=0. Array contents are not reset; the next run rewrites every entry.

Reset values:
- `test_busy`=0, `test_return`=0.
- `test_ok`=0 when the check is compiled in; constant 1 otherwise.

## Timing

- Request sampled high in IDLE at edge 0 → busy=1 from edge 1.
- Busy lasts 1 (INIT) + DEPTH (FILL) + DEPTH+1 (SUM incl. read latency) + 1 (DONE) = 2·DEPTH+3 cycles. That is 35 cycles for DEPTH=16.
- `test_return` updates on the edge that leaves DONE, i.e. the same edge on which busy falls.
- Back-to-back runs with req held high: period 2·DEPTH+4 cycles.
- RAM is single-port with one-cycle read latency. Writes and reads never occur in the same cycle.

## Configuration

- Macro: `TEST003_SELFCHECK_EN`.
- Defined: in DONE, acc is compared with the constant DEPTH·(DEPTH-1)·(2·DEPTH-1)/6, truncated to WIDTH. `test_ok` is registered with the result on the same edge as `test_return`. It is cleared to 0 on reset and on entry to INIT.
- Undefined: no comparator is built and `test_ok` is tied to 1.

## Structure

- Package `test_003_pkg` holds:
  - the state enum (IDLE, INIT, FILL, SUM, DONE);
  - default DEPTH and WIDTH constants;
  - a constant function for the expected sum of squares.
- Sub-module `test_003_ram`: single-port synchronous RAM, DEPTH×WIDTH, registered read data (1-cycle latency), no reset.
- The top level holds the FSM, index counter, accumulator and output registers.

## Test plan

- Reset held 5 cycles, req=0 → busy=0, `test_return`=0, `test_ok`=0 (macro on) or 1 (off). Stays idle for 20 cycles.
- Single 1-cycle req pulse, DEPTH=16 → busy high for exactly 35 cycles, then `test_return`=1240 and `test_ok`=1.
- req held high permanently → busy low for exactly 1 cycle every 36 cycles; `test_return` stays 1240.
- Reset asserted 10 cycles into a run → busy=0 and `test_return`=0 next cycle. A new req then yields 1240 after 35 busy cycles.
- DEPTH=2 and DEPTH=256 → results 1 and 5559680; busy lengths 7 and 515 cycles.
- req toggled during a run → no effect on duration or result.
